// File: rtl/cache_controller_pkg.sv
// Shared geometry constants and FSM state type for the direct-mapped
// write-through cache controller.
package cache_controller_pkg;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned INDEX_W   = 5;
    localparam int unsigned OFFSET_W  = 2;
    localparam int unsigned TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned NUM_LINES = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        FILL    = 2'd2,
        WR_THRU = 2'd3
    } state_t;

endpackage

// File: rtl/cache_tag_store.sv
// Tag array plus valid vector: combinational lookup, single write port,
// asynchronous clear of the valid bits (tags are left as-is).
module cache_tag_store
    import cache_controller_pkg::*;
#(
    parameter int unsigned LINE_IDX_W = INDEX_W,
    parameter int unsigned LINE_TAG_W = TAG_W
) (
    input  logic                  clk,
    input  logic                  clr_i,
    input  logic [LINE_IDX_W-1:0] lk_index_i,
    input  logic [LINE_TAG_W-1:0] lk_tag_i,
    output logic                  lk_hit_o,
    input  logic                  wr_en_i,
    input  logic [LINE_IDX_W-1:0] wr_index_i,
    input  logic [LINE_TAG_W-1:0] wr_tag_i
);

    localparam int unsigned LINES = 1 << LINE_IDX_W;

    logic [LINE_TAG_W-1:0] tag_q [LINES];
    logic [LINES-1:0]      valid_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_index_i] <= wr_tag_i;
        end
    end

    always_ff @(posedge clk or posedge clr_i) begin
        if (clr_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    assign lk_hit_o = valid_q[lk_index_i] && (tag_q[lk_index_i] == lk_tag_i);

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller FSM.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int unsigned ADDR_W   = cache_controller_pkg::ADDR_W,
    parameter int unsigned INDEX_W  = cache_controller_pkg::INDEX_W,
    parameter int unsigned OFFSET_W = cache_controller_pkg::OFFSET_W,
    parameter int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic                     cpu_read,
    input  logic                     cpu_write,
    input  logic [31:0]              cpu_wdata,
    output logic                     stall,
    output logic                     hit,
    output logic                     miss,
    output logic                     fill,
    output logic                     mem_req,
    output logic [ADDR_W-OFFSET_W-1:0] mem_baddr,
    input  logic                     mem_ready,
    output logic                     mem_wr,
    output logic [ADDR_W-1:0]        mem_waddr,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_wr_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]              hit_cnt,
    output logic [15:0]              miss_cnt
`endif
);

    localparam int unsigned BLK_W = ADDR_W - OFFSET_W;

    state_t             state_q, state_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               whit_q, whit_d;

    logic lk_hit, tag_we;
    logic stall_c, hit_c, miss_c, fill_c, mem_req_c, mem_wr_c;

    cache_tag_store #(
        .LINE_IDX_W (INDEX_W),
        .LINE_TAG_W (TAG_W)
    ) u_tags (
        .clk        (clk),
        .clr_i      (rst),
        .lk_index_i (cpu_addr[OFFSET_W +: INDEX_W]),
        .lk_tag_i   (cpu_addr[ADDR_W-1 -: TAG_W]),
        .lk_hit_o   (lk_hit),
        .wr_en_i    (tag_we),
        .wr_index_i (blk_q[INDEX_W-1:0]),
        .wr_tag_i   (blk_q[BLK_W-1 -: TAG_W])
    );

    always_comb begin
        state_d   = state_q;
        blk_d     = blk_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        whit_d    = whit_q;
        stall_c   = 1'b0;
        hit_c     = 1'b0;
        miss_c    = 1'b0;
        fill_c    = 1'b0;
        mem_req_c = 1'b0;
        mem_wr_c  = 1'b0;
        tag_we    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A simultaneous read and write is served as a read only.
                if (cpu_read) begin
                    hit_c   = lk_hit;
                    miss_c  = !lk_hit;
                    stall_c = !lk_hit;
                    if (!lk_hit) begin
                        blk_d   = cpu_addr[ADDR_W-1:OFFSET_W];
                        state_d = RD_MISS;
                    end
                end else if (cpu_write) begin
                    hit_c   = lk_hit;
                    miss_c  = !lk_hit;
                    stall_c = 1'b1;
                    waddr_d = cpu_addr;
                    wdata_d = cpu_wdata;
                    whit_d  = lk_hit;
                    state_d = WR_THRU;
                end
            end
            RD_MISS: begin
                miss_c    = 1'b1;
                stall_c   = 1'b1;
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    tag_we  = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                fill_c  = 1'b1;
                state_d = IDLE;
            end
            WR_THRU: begin
                mem_wr_c = 1'b1;
                stall_c  = 1'b1;
                hit_c    = whit_q;
                miss_c   = !whit_q;
                if (mem_wr_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            blk_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            whit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            whit_q  <= whit_d;
        end
    end

    // Reset masks the outputs directly so they drop in the same instant,
    // even while the CPU is still holding a request.
    assign stall     = stall_c   & ~rst;
    assign hit       = hit_c     & ~rst;
    assign miss      = miss_c    & ~rst;
    assign fill      = fill_c    & ~rst;
    assign mem_req   = mem_req_c & ~rst;
    assign mem_wr    = mem_wr_c  & ~rst;
    assign mem_baddr = mem_req ? blk_q   : '0;
    assign mem_waddr = mem_wr  ? waddr_q : '0;
    assign mem_wdata = mem_wr  ? wdata_q : '0;

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;
    logic        lookup_done;

    assign lookup_done = (state_q == IDLE) && (cpu_read || cpu_write);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (lookup_done) begin
            if (lk_hit && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (!lk_hit && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed scenarios followed by
// random traffic, all checked against an array model of tags/valid bits.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  cpu_addr = '0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_wdata = '0;
    logic        stall, hit, miss, fill, mem_req, mem_wr;
    logic [7:0]  mem_baddr;
    logic [9:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic        mem_wr_ack = 1'b0;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
    int          hit_m = 0;
    int          miss_m = 0;
`endif

    int checks = 0;
    int errors = 0;

    logic [2:0] mtag [32];
    bit   [31:0] mvalid = '0;

    cache_controller dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_wdata  (cpu_wdata),
        .stall      (stall),
        .hit        (hit),
        .miss       (miss),
        .fill       (fill),
        .mem_req    (mem_req),
        .mem_baddr  (mem_baddr),
        .mem_ready  (mem_ready),
        .mem_wr     (mem_wr),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wr_ack (mem_wr_ack)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit(input logic [9:0] a);
        return mvalid[a[6:2]] && (mtag[a[6:2]] == a[9:7]);
    endfunction

    task automatic count_lookup(input bit h);
`ifdef CACHE_STATS_EN
        if (h) hit_m = (hit_m < 65535) ? hit_m + 1 : 65535;
        else   miss_m = (miss_m < 65535) ? miss_m + 1 : 65535;
`else
        if (h) begin end
`endif
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, {26'b0, stall, hit, miss, fill, mem_req, mem_wr}, 32'h0);
        check({tag, "_bus"}, mem_wdata | {22'b0, mem_waddr} | {24'b0, mem_baddr}, 32'h0);
    endtask

    // Read (or read+write collision) with 'lat' waiting RD_MISS cycles before mem_ready.
    task automatic do_read(input logic [9:0] a, input int lat, input bit both);
        bit exp_hit;
        exp_hit = model_hit(a);
        count_lookup(exp_hit);
        @(negedge clk);
        cpu_addr  = a;
        cpu_read  = 1'b1;
        cpu_write = both;
        cpu_wdata = $urandom;
        #1;
        check("rd_hit",   {31'b0, hit},   {31'b0, exp_hit});
        check("rd_miss",  {31'b0, miss},  {31'b0, !exp_hit});
        check("rd_stall", {31'b0, stall}, {31'b0, !exp_hit});
        check("rd_noreq", {30'b0, mem_req, mem_wr}, 32'h0);
        if (exp_hit) begin
            @(negedge clk);
            cpu_read  = 1'b0;
            cpu_write = 1'b0;
            #1;
            check_quiet("rd_after_hit");
            return;
        end
        for (int i = 0; i <= lat; i++) begin
            @(negedge clk);
            mem_wr_ack = (i == 0) && (lat > 0);
            mem_ready  = (i == lat);
            #1;
            check("rdm_req",   {31'b0, mem_req}, 32'h1);
            check("rdm_baddr", {24'b0, mem_baddr}, {24'b0, a[9:2]});
            check("rdm_ctl",   {27'b0, stall, hit, miss, fill, mem_wr}, 32'b10100);
        end
        @(negedge clk);
        mem_ready  = 1'b0;
        mem_wr_ack = 1'b0;
        cpu_read   = 1'b0;
        cpu_write  = 1'b0;
        #1;
        check("fill_ctl", {26'b0, stall, hit, miss, fill, mem_req, mem_wr}, 32'b000100);
        mtag[a[6:2]]   = a[9:7];
        mvalid[a[6:2]] = 1'b1;
        @(negedge clk);
        #1;
        check_quiet("after_fill");
    endtask

    task automatic do_write(input logic [9:0] a, input logic [31:0] d, input int lat);
        bit exp_hit;
        exp_hit = model_hit(a);
        count_lookup(exp_hit);
        @(negedge clk);
        cpu_addr  = a;
        cpu_write = 1'b1;
        cpu_wdata = d;
        #1;
        check("wr_hit",   {31'b0, hit},   {31'b0, exp_hit});
        check("wr_miss",  {31'b0, miss},  {31'b0, !exp_hit});
        check("wr_stall", {31'b0, stall}, 32'h1);
        check("wr_nomem", {30'b0, mem_req, mem_wr}, 32'h0);
        for (int i = 0; i <= lat; i++) begin
            @(negedge clk);
            cpu_wdata  = $urandom;
            mem_ready  = (i == 0) && (lat > 0);
            mem_wr_ack = (i == lat);
            #1;
            check("wt_ctl",   {26'b0, stall, hit, miss, fill, mem_req, mem_wr},
                              {26'b0, 1'b1, exp_hit, !exp_hit, 1'b0, 1'b0, 1'b1});
            check("wt_waddr", {22'b0, mem_waddr}, {22'b0, a});
            check("wt_wdata", mem_wdata, d);
        end
        @(negedge clk);
        mem_ready  = 1'b0;
        mem_wr_ack = 1'b0;
        cpu_write  = 1'b0;
        #1;
        check_quiet("after_wr");
    endtask

    initial begin
        // Reset with no request.
        #12;
        check_quiet("in_reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_quiet("post_reset");

        // Stray handshakes in IDLE must be ignored.
        @(negedge clk);
        mem_ready  = 1'b1;
        mem_wr_ack = 1'b1;
        @(negedge clk);
        mem_ready  = 1'b0;
        mem_wr_ack = 1'b0;
        #1;
        check_quiet("stray_pulses");

        do_read(10'h380, 3, 1'b0);
        check("valid0_after_fill", {31'b0, mvalid[0]}, 32'h1);
        do_read(10'h381, 0, 1'b0);
        do_read(10'h080, 1, 1'b0);
        do_read(10'h380, 2, 1'b0);
        do_write(10'h380, 32'h7E8, 2);
        do_write(10'h200, 32'hCAFE_0200, 0);
        do_read(10'h381, 0, 1'b0);
        do_read(10'h3FC, 1, 1'b1);

        // Reset in the middle of a read miss.
        @(negedge clk);
        cpu_addr = 10'h080;
        cpu_read = 1'b1;
        count_lookup(model_hit(10'h080));
        @(negedge clk);
        #1;
        check("pre_rst_req", {31'b0, mem_req}, 32'h1);
        rst = 1'b1;
        #1;
        check_quiet("rst_mid_miss");
        cpu_read = 1'b0;
        mvalid = '0;
`ifdef CACHE_STATS_EN
        hit_m = 0;
        miss_m = 0;
`endif
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check_quiet("late_ready");
        do_read(10'h381, 1, 1'b0);

        // Random traffic concentrated on a few lines to mix hits and misses.
        for (int n = 0; n < 150; n++) begin
            logic [9:0] a;
            int unsigned op;
            a  = {3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            op = $urandom_range(0, 2);
            if (op == 0)      do_read(a, $urandom_range(0, 4), 1'b0);
            else if (op == 1) do_write(a, $urandom, $urandom_range(0, 4));
            else              do_read(a, $urandom_range(0, 4), 1'b1);
        end

`ifdef CACHE_STATS_EN
        check("hit_cnt",  {16'b0, hit_cnt},  32'(hit_m));
        check("miss_cnt", {16'b0, miss_cnt}, 32'(miss_m));
        do_read(10'h381, 0, 1'b0);
        @(negedge clk);
        cpu_addr = 10'h381;
        cpu_read = 1'b1;
        repeat (70000) @(negedge clk);
        cpu_read = 1'b0;
        #1;
        check("hit_cnt_sat", {16'b0, hit_cnt}, 32'h0000_FFFF);
        check("miss_cnt_hold", {16'b0, miss_cnt}, 32'(miss_m));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
